rom_arbiter: RTL and testbench

- Shares the single synchronous-read instruction ROM (10-bit word address, 32-bit data, one-cycle read latency) between two requesters: instruction fetch (IF, port 0) and data-memory load path (MEM, port 1).
- Per-port req/ack handshake, one transaction in flight.
- Sits between the fetch/memory stages and the ROM instance; owns the ROM address bus.

---
 rtl/rom_arb_pkg.sv | 18 +
 rtl/rom_arbiter_if.sv | 25 ++
 rtl/rom_arbiter_arb2.sv | 50 +++++
 rtl/rom_arbiter.sv | 92 +++++++++
 tb/tb_rom_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the instruction-ROM arbiter.
// Round-robin arbitration is enabled with ROM_ARB_ROUND_ROBIN_EN.
package rom_arb_pkg;

  localparam int unsigned ROM_ADDR_W = 10;
  localparam int unsigned ROM_DATA_W = 32;

  localparam logic PORT_IF  = 1'b0;
  localparam logic PORT_MEM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side bundle of the ROM arbiter: two req/ack ports plus shared response/status.
interface rom_arbiter_if;
  import rom_arb_pkg::*;

  logic                  if_req;
  logic [ROM_ADDR_W-1:0] if_addr;
  logic                  if_ack;
  logic                  mem_req;
  logic [ROM_ADDR_W-1:0] mem_addr;
  logic                  mem_ack;
  logic [ROM_DATA_W-1:0] resp_data;
  logic                  busy;
  logic                  grant_id;

  modport master (
    output if_req, if_addr, mem_req, mem_addr,
    input  if_ack, mem_ack, resp_data, busy, grant_id
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_addr,
    output if_ack, mem_ack, resp_data, busy, grant_id
  );

endinterface

// File: rtl/rom_arbiter_arb2.sv
// Two-port winner select. Fixed MEM > IF priority by default; with
// ROM_ARB_ROUND_ROBIN_EN a pointer register favours the port not last granted.
module arb2
  import rom_arb_pkg::*;
(
`ifdef ROM_ARB_ROUND_ROBIN_EN
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       grant_i,
`endif
  input  logic [1:0] req_i,
  output logic       winner_c_o
);

`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic ptr_q;
  logic ptr_d;

  // Pointer names the preferred port on a tie; it moves off whoever just won.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_i) begin
      ptr_d = ~winner_c_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= PORT_IF;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    winner_c_o = PORT_IF;
    if (req_i == 2'b11) begin
      winner_c_o = ptr_q;
    end else if (req_i[PORT_MEM]) begin
      winner_c_o = PORT_MEM;
    end
  end
`else
  // Winner is don't-care when nothing is requested.
  always_comb begin
    winner_c_o = req_i[PORT_MEM] | ~req_i[PORT_IF];
  end
`endif

endmodule

// File: rtl/rom_arbiter.sv
// Shares one synchronous-read instruction ROM between IF (port 0) and MEM (port 1).
// Arbitration policy selected by ROM_ARB_ROUND_ROBIN_EN (see arb2).
module rom_arbiter
  import rom_arb_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  rom_arbiter_if.slave          bus,
  output logic [ROM_ADDR_W-1:0] rom_addr_o,
  input  logic [ROM_DATA_W-1:0] rom_rdata_i
);

  localparam int unsigned ADDR_W = ROM_ADDR_W;
  localparam int unsigned DATA_W = ROM_DATA_W;

  state_e              state_q, state_d;
  logic [1:0]          ack_q, ack_d;
  logic [DATA_W-1:0]   resp_q, resp_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [1:0]          req_c;
  logic                winner_c;
  logic                grant_fire_c;

  assign req_c = {bus.mem_req, bus.if_req};

  arb2 u_arb2 (
`ifdef ROM_ARB_ROUND_ROBIN_EN
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .grant_i    (grant_fire_c),
`endif
    .req_i      (req_c),
    .winner_c_o (winner_c)
  );

  // Next-state and datapath; the address is frozen at grant time.
  always_comb begin
    state_d      = state_q;
    ack_d        = 2'b00;
    resp_d       = resp_q;
    rom_addr_d   = rom_addr_q;
    grant_d      = grant_q;
    grant_fire_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_c) begin
          grant_fire_c = 1'b1;
          grant_d      = winner_c;
          rom_addr_d   = (winner_c == PORT_MEM) ? bus.mem_addr : bus.if_addr;
          state_d      = ST_ADDR;
        end
      end
      ST_ADDR: state_d = ST_DATA;
      ST_DATA: begin
        resp_d         = rom_rdata_i;
        ack_d[grant_q] = 1'b1;
        state_d        = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      ack_q      <= 2'b00;
      resp_q     <= '0;
      rom_addr_q <= '0;
      grant_q    <= PORT_IF;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      resp_q     <= resp_d;
      rom_addr_q <= rom_addr_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.if_ack    = ack_q[PORT_IF];
  assign bus.mem_ack   = ack_q[PORT_MEM];
  assign bus.resp_data = resp_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_q;
  assign rom_addr_o    = rom_addr_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter; expectations follow ROM_ARB_ROUND_ROBIN_EN when defined.
module tb_rom_arbiter;
  import rom_arb_pkg::*;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b0;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [ROM_DATA_W-1:0] rom_rdata = '0;
  logic [31:0]           rom_mem [1024];

  int   checks      = 0;
  int   failures    = 0;
  int   if_acks     = 0;
  int   mem_acks    = 0;
  int   hold_target = 0;
  bit   auto_drop   = 1'b1;
  exp_t sb[$];
  exp_t mon_e;

  rom_arbiter_if bus();

  rom_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .rom_addr_o  (rom_addr),
    .rom_rdata_i (rom_rdata)
  );

  always #5 clk = ~clk;

  // One-cycle-latency ROM model.
  always @(posedge clk) rom_rdata <= rom_mem[rom_addr];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: observed=%h expected=%h", tag, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every Ack and releases requests.
  always @(negedge clk) begin
    if (bus.if_ack || bus.mem_ack) begin
      check_eq("single_ack", 32'(bus.if_ack & bus.mem_ack), 32'd0);
      check_eq("busy_in_resp", 32'(bus.busy), 32'd1);
      if (sb.size() == 0) begin
        check_eq("unexpected_ack", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("ack_port", 32'(bus.mem_ack), 32'(mon_e.port));
        check_eq("grant_id", 32'(bus.grant_id), 32'(mon_e.port));
        check_eq("resp_data", bus.resp_data, mon_e.data);
      end
      if (bus.if_ack)  if_acks++;
      if (bus.mem_ack) mem_acks++;
      if (auto_drop) begin
        if (bus.if_ack)  bus.if_req  = 1'b0;
        if (bus.mem_ack) bus.mem_req = 1'b0;
      end else if (if_acks + mem_acks == hold_target) begin
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
      end
    end
  end

  task automatic do_reset();
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    if_acks   = 0;
    mem_acks  = 0;
    auto_drop = 1'b1;
    sb.delete();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !bus.busy && !bus.if_req && !bus.mem_req) break;
    end
    check_eq(tag, 32'(i < budget), 32'd1);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 1024; k++) rom_mem[k] = 32'hA000_0000 + 32'(k);
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;

    // Reset values
    do_reset();
    check_eq("rst_if_ack", 32'(bus.if_ack), 32'd0);
    check_eq("rst_mem_ack", 32'(bus.mem_ack), 32'd0);
    check_eq("rst_resp", bus.resp_data, 32'd0);
    check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_grant", 32'(bus.grant_id), 32'd0);

    // Single IF access with latency measurement
    sb.push_back({PORT_IF, 32'hA000_0005});
    bus.if_addr = 10'd5;
    bus.if_req  = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.if_ack && n < 8);
    check_eq("t2_latency", 32'(n), 32'd3);
    wait_done("t2_done", 20);
    check_eq("t2_if_acks", 32'(if_acks), 32'd1);
    check_eq("t2_mem_acks", 32'(mem_acks), 32'd0);

    // Simultaneous requests
    do_reset();
`ifdef ROM_ARB_ROUND_ROBIN_EN
    sb.push_back({PORT_IF,  32'hA000_0001});
    sb.push_back({PORT_MEM, 32'hA000_0002});
`else
    sb.push_back({PORT_MEM, 32'hA000_0002});
    sb.push_back({PORT_IF,  32'hA000_0001});
`endif
    bus.if_addr  = 10'd1;
    bus.mem_addr = 10'd2;
    bus.if_req   = 1'b1;
    bus.mem_req  = 1'b1;
    wait_done("t3_done", 40);
    check_eq("t3_if_acks", 32'(if_acks), 32'd1);
    check_eq("t3_mem_acks", 32'(mem_acks), 32'd1);

    // Both requests held for eight transactions
    do_reset();
    auto_drop   = 1'b0;
    hold_target = 8;
    for (int i = 0; i < 8; i++) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
      if (i % 2 == 0) sb.push_back({PORT_IF, 32'hA000_0014});
      else            sb.push_back({PORT_MEM, 32'hA000_001E});
`else
      sb.push_back({PORT_MEM, 32'hA000_001E});
`endif
    end
    bus.if_addr  = 10'd20;
    bus.mem_addr = 10'd30;
    bus.if_req   = 1'b1;
    bus.mem_req  = 1'b1;
    wait_done("t4_done", 80);
`ifdef ROM_ARB_ROUND_ROBIN_EN
    check_eq("t4_if_acks", 32'(if_acks), 32'd4);
    check_eq("t4_mem_acks", 32'(mem_acks), 32'd4);
`else
    check_eq("t4_if_acks", 32'(if_acks), 32'd0);
    check_eq("t4_mem_acks", 32'(mem_acks), 32'd8);
`endif
    auto_drop = 1'b1;

    // Address changed after grant must not affect the access
    do_reset();
    sb.push_back({PORT_MEM, 32'hA000_0003});
    bus.mem_addr = 10'd3;
    bus.mem_req  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mem_addr = 10'd9;
    wait_done("t5_done", 20);
    check_eq("t5_rom_addr_hold", 32'(rom_addr), 32'd3);
    check_eq("t5_grant_hold", 32'(bus.grant_id), 32'd1);

    // Reset while in DATA drops the access
    if_acks  = 0;
    mem_acks = 0;
    bus.mem_addr = 10'd7;
    bus.mem_req  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("t6_busy_data", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus.mem_req = 1'b0;
    check_eq("t6_busy", 32'(bus.busy), 32'd0);
    check_eq("t6_resp", bus.resp_data, 32'd0);
    check_eq("t6_ack", 32'({bus.mem_ack, bus.if_ack}), 32'd0);
    check_eq("t6_grant", 32'(bus.grant_id), 32'd0);
    check_eq("t6_rom_addr", 32'(rom_addr), 32'd0);
    repeat (4) @(negedge clk);
    check_eq("t6_no_ack", 32'(mem_acks + if_acks), 32'd0);
    sb.push_back({PORT_IF, 32'hA000_000C});
    bus.if_addr = 10'd12;
    bus.if_req  = 1'b1;
    wait_done("t6_done", 20);
    check_eq("t6_if_acks", 32'(if_acks), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
